// File: rtl/module_i2s_tx.sv
// I2S transmitter: sample FIFO feeding a 64-BCLK stereo frame. The same 18-bit sample
// is sent in both slots, MSB first, with the standard one-BCLK data delay.
//   state   | meaning
//   ST_IDLE | serial outputs parked low, waiting for enable and at least two buffered samples
//   ST_RUN  | generating BCLK/LRCLK/data; stops only at a frame boundary
module module_i2s_tx #(
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_in_rdy,
    input  logic [17:0] sample_in,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_data,
    output logic        fifo_overflow,
    output logic        fifo_underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t          state, state_next;
    logic [17:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_full, fifo_empty, push, pop, overflow_next;

    logic [7:0]      div_cnt, div_next;
    logic [5:0]      bit_cnt, bit_next, k_next;
    logic [31:0]     word, word_next;
    logic            bclk_next, lrclk_next, data_next, underrun_next, fall;

    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign fifo_empty    = (count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO may still accept
    assign push          = sample_in_rdy && (!fifo_full || pop);
    assign overflow_next = sample_in_rdy && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        div_next      = div_cnt;
        bit_next      = bit_cnt;
        bclk_next     = i2s_bclk;
        lrclk_next    = i2s_lrclk;
        data_next     = i2s_data;
        word_next     = word;
        pop           = 1'b0;
        underrun_next = 1'b0;
        fall          = 1'b0;
        k_next        = bit_cnt + 6'd1;
        case (state)
            ST_IDLE: begin
                div_next   = '0;
                bit_next   = '0;
                bclk_next  = 1'b0;
                lrclk_next = 1'b0;
                data_next  = 1'b0;
                if (enable && count >= CW'(2)) begin
                    pop        = 1'b1;
                    word_next  = {mem[rd_ptr], 14'b0};
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (div_cnt == DIV_LAST) begin
                    div_next  = '0;
                    bclk_next = !i2s_bclk;
                    fall      = i2s_bclk;
                end else begin
                    div_next = div_cnt + 8'd1;
                end
                if (fall) begin
                    bit_next   = k_next;
                    lrclk_next = k_next[5];
                    // slot position k sends word[32-k]; modulo 32 that is word[-k]
                    data_next  = (k_next[4:0] == 5'd0) ? 1'b0 : word[5'd0 - k_next[4:0]];
                    if (k_next == 6'd0) begin
                        if (!enable) begin
                            state_next = ST_IDLE;
                            bclk_next  = 1'b0;
                            lrclk_next = 1'b0;
                            data_next  = 1'b0;
                        end else if (fifo_empty) begin
                            underrun_next = 1'b1;
                        end else begin
                            pop       = 1'b1;
                            word_next = {mem[rd_ptr], 14'b0};
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            word          <= '0;
            i2s_bclk      <= 1'b0;
            i2s_lrclk     <= 1'b0;
            i2s_data      <= 1'b0;
            fifo_overflow <= 1'b0;
            fifo_underrun <= 1'b0;
        end else begin
            div_cnt       <= div_next;
            bit_cnt       <= bit_next;
            word          <= word_next;
            i2s_bclk      <= bclk_next;
            i2s_lrclk     <= lrclk_next;
            i2s_data      <= data_next;
            fifo_overflow <= overflow_next;
            fifo_underrun <= underrun_next;
        end
    end

endmodule
